multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state updates occur on the rising edge.
REQ-002 SHALL have rst_n, input, 1, synchronous active-low reset, sampled on the rising clk edge.
REQ-003 SHALL have op, input, 7, opcode field of the instruction register.
REQ-004 SHALL have funct3, input, 3, branch-condition select.
REQ-005 SHALL have Zero and ALUR31, inputs, 1 each, ALU result flags.
REQ-006 SHALL have mem_ready, input, 1, memory-access completion strobe.
REQ-007 SHALL have PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, outputs, 1 each, datapath strobes/selects.
REQ-008 SHALL have ALUSrcA, ALUSrcB, ResultSrc, ALUOp, immSrc, outputs, 2 each, datapath selects.
REQ-009 SHALL have state, output, 4, current FSM state; illegal, output, 1, sticky unsupported-opcode flag.

Function
REQ-010 SHALL implement a Moore FSM whose outputs are decoded from state, except PCWrite in BRANCH, the mem_ready qualification and immSrc.
REQ-011 SHALL use this encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, TRAP=15.
REQ-012 SHALL default to 0 on every output not listed for a state.
REQ-013 SHALL set the select encodings as follows: ALUSrcA 00=PC, 01=OldPC, 10=rs1; ALUSrcB 00=rs2, 01=imm, 10=const4; ResultSrc 00=ALUOut, 01=Data, 10=ALUResult; AdrSrc 0=PC, 1=Result.
REQ-014 SHALL, in FETCH, drive AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, and assert IRWrite=PCWrite=1 only in the cycle mem_ready=1, then go to DECODE.
REQ-015 SHALL, in DECODE, drive ALUSrcA=01, ALUSrcB=01, ALUOp=00, and go to MEMADR for op 0000011/0100011, EXECR for 0110011, EXECI for 0010011, BRANCH for 1100011, JAL for 1101111, and TRAP for any other op.
REQ-016 SHALL, in MEMADR, drive ALUSrcA=10, ALUSrcB=01, ALUOp=00, then go to MEMREAD for lw and MEMWRITE for sw.
REQ-017 SHALL, in MEMREAD, drive AdrSrc=1, ResultSrc=00, hold the state until mem_ready=1, then go to MEMWB.
REQ-018 SHALL, in MEMWRITE, drive AdrSrc=1, ResultSrc=00, MemWrite=1, hold MemWrite until mem_ready=1, then go to FETCH.
REQ-019 SHALL, in MEMWB, drive ResultSrc=01, RegWrite=1, then go to FETCH.
REQ-020 SHALL, in EXECR (ALUSrcB=00) and EXECI (ALUSrcB=01), drive ALUSrcA=10, ALUOp=10, then go to ALUWB.
REQ-021 SHALL, in ALUWB, drive ResultSrc=00, RegWrite=1, then go to FETCH.
REQ-022 SHALL, in BRANCH, drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, and PCWrite=taken, then go to FETCH.
REQ-023 SHALL compute taken by funct3: 000 Zero; 001 !Zero; 100/110 ALUR31; 101/111 !ALUR31; 010/011 0.
REQ-024 SHALL, in JAL, drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then go to ALUWB.
REQ-025 SHALL, in TRAP, drive all strobes to 0, set illegal=1, and remain in TRAP until reset.
REQ-026 SHALL decode immSrc combinationally from op in every state: 0000011/0010011=00, 0100011=01, 1100011=10, 1101111=11, other=00.
REQ-027 SHALL give a CPI of 3 (branch), 4 (R/I/jal/sw) and 5 (lw) with zero memory wait.

Reset
REQ-028 SHALL load state=FETCH and illegal=0 on a rising edge with rst_n=0.
REQ-029 SHALL force PCWrite, IRWrite, MemWrite and RegWrite to 0 combinationally while rst_n=0, including a reset applied mid-instruction or mid-wait.

Configuration
REQ-030 SHALL, when MC_MEM_WAIT_EN is defined, apply the mem_ready qualification of REQ-014/017/018.
REQ-031 SHALL, when MC_MEM_WAIT_EN is undefined, ignore mem_ready and treat it as constant 1, so FETCH, MEMREAD and MEMWRITE each last one cycle.

Verification
REQ-032 SHALL pass this scenario: reset, op=0110011, mem_ready=1 -> states 0,1,6,8,0; RegWrite=1 only in state 8.
REQ-033 SHALL pass this scenario: op=0000011, MC_MEM_WAIT_EN defined, mem_ready held 0 for 3 cycles in MEMREAD -> state 3 for 4 cycles, then 4 with ResultSrc=01 and RegWrite=1.
REQ-034 SHALL pass this scenario: op=1100011, funct3=001, Zero=0 -> PCWrite=1 in state 9; with Zero=1 -> PCWrite=0.
REQ-035 SHALL pass this scenario: op=0100011, mem_ready=0 for 2 cycles -> MemWrite=1 for 3 cycles, then state 0.
REQ-036 SHALL pass this scenario: op=1111111 -> state 15, illegal=1, strobes 0 for 10 cycles; rst_n=0 for one edge -> state 0, illegal=0.
REQ-037 SHALL pass this scenario: rst_n=0 asserted while in state 5 -> MemWrite=0 in the same cycle, state 0 after the edge.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control FSM for a multi-cycle RISC-V style datapath (lw, sw, R-type,
//   I-type ALU, conditional branches, jal). The outputs are decoded from the
//   current state. The exceptions are PCWrite in BRANCH, the mem_ready
//   handshake in FETCH/MEMREAD/MEMWRITE, and immSrc, which is decoded from op.
//
//   Build option: MC_MEM_WAIT_EN
//     defined   : FETCH, MEMREAD and MEMWRITE wait for mem_ready.
//     undefined : mem_ready is ignored; those states each last one cycle.
//
//   Ports
//     clk, rst_n          : clock, synchronous active-low reset
//     op, funct3          : instruction opcode / branch condition select
//     Zero, ALUR31        : ALU result flags
//     mem_ready           : memory access completion strobe
//     PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc : datapath strobes/selects
//     ALUSrcA, ALUSrcB, ResultSrc, ALUOp, immSrc   : datapath selects
//     state               : current FSM state
//     illegal             : sticky flag for an unsupported opcode
//
//   state    | meaning
//   FETCH    | read instruction at PC, PC <= PC+4
//   DECODE   | read registers, compute branch/jump target
//   MEMADR   | compute load/store address
//   MEMREAD  | load data from memory
//   MEMWB    | write loaded data to rd
//   MEMWRITE | store rs2 to memory
//   EXECR    | ALU op rs1, rs2
//   EXECI    | ALU op rs1, imm
//   ALUWB    | write ALUOut to rd
//   BRANCH   | compare, PC <= target when taken
//   JAL      | PC <= target, ALUOut <= PC+4 (old PC)
//   TRAP     | unsupported opcode, held until reset

module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       ALUR31,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic [1:0] immSrc,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   mem_ok;
  logic   taken;
  logic   pcw, irw, mw, rw;

`ifdef MC_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:         taken = Zero;
      3'b001:         taken = ~Zero;
      3'b100, 3'b110: taken = ALUR31;
      3'b101, 3'b111: taken = ~ALUR31;
      default:        taken = 1'b0;
    endcase
  end

  always_comb begin
    immSrc = 2'b00;
    case (op)
      OP_SW:   immSrc = 2'b01;
      OP_BR:   immSrc = 2'b10;
      OP_JAL:  immSrc = 2'b11;
      default: immSrc = 2'b00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pcw       = 1'b0;
    irw       = 1'b0;
    mw        = 1'b0;
    rw        = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 2'b00;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ok) begin
          pcw     = 1'b1;
          irw     = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ok) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rw        = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mw     = 1'b1;
        if (mem_ok) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rw      = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        pcw     = taken;
        state_d = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pcw     = 1'b1;
        state_d = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Set on the same edge that enters TRAP so the flag and state agree.
  assign illegal_d = illegal_q | (state_d == S_TRAP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Write strobes are masked while reset is held, even mid-instruction.
  assign PCWrite  = pcw & rst_n;
  assign IRWrite  = irw & rst_n;
  assign MemWrite = mw  & rst_n;
  assign RegWrite = rw  & rst_n;
  assign state    = state_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       Zero, ALUR31, mem_ready;
  logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp, immSrc;
  logic [3:0] state;
  logic       illegal;
  logic [12:0] outs;

  int checks   = 0;
  int failures = 0;

`ifdef MC_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .Zero(Zero),
    .ALUR31(ALUR31), .mem_ready(mem_ready), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUOp(ALUOp), .immSrc(immSrc),
    .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign outs = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc,
                 ALUSrcA, ALUSrcB, ResultSrc, ALUOp};

  typedef struct {
    logic [6:0]      op;
    logic [2:0]      f3;
    logic            z;
    logic            r31;
    logic            taken;
    int              cpi;
    logic [0:4][3:0] seq;
    logic [1:0]      imm;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Expected strobes/selects per state, written from the control table.
  function automatic logic [12:0] exp_outs(input logic [3:0] st, input logic mr,
                                           input logic tk, input logic rn);
    logic pcw, irw, mw, rw, adr;
    logic [1:0] a, b, r, alu;
    pcw = 0; irw = 0; mw = 0; rw = 0; adr = 0;
    a = 0; b = 0; r = 0; alu = 0;
    case (st)
      4'd0:  begin b = 2'b10; r = 2'b10; pcw = mr; irw = mr; end
      4'd1:  begin a = 2'b01; b = 2'b01; end
      4'd2:  begin a = 2'b10; b = 2'b01; end
      4'd3:  begin adr = 1; end
      4'd4:  begin r = 2'b01; rw = 1; end
      4'd5:  begin adr = 1; mw = 1; end
      4'd6:  begin a = 2'b10; alu = 2'b10; end
      4'd7:  begin a = 2'b10; b = 2'b01; alu = 2'b10; end
      4'd8:  begin rw = 1; end
      4'd9:  begin a = 2'b10; alu = 2'b01; pcw = tk; end
      4'd10: begin a = 2'b01; b = 2'b10; pcw = 1; end
      default: ;
    endcase
    if (!rn) begin pcw = 0; irw = 0; mw = 0; rw = 0; end
    return {pcw, irw, mw, rw, adr, a, b, r, alu};
  endfunction

  function automatic logic mr_eff(input logic mr);
    return WAIT_EN ? mr : 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic to_fetch();
    for (int i = 0; i < 8 && state != 4'd0; i++) step();
    chk("return_to_fetch", state, 4'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    op = v.op; funct3 = v.f3; Zero = v.z; ALUR31 = v.r31; mem_ready = 1'b1;
    #1;
    chk($sformatf("v%0d_immSrc", idx), immSrc, v.imm);
    for (int c = 0; c < v.cpi; c++) begin
      chk($sformatf("v%0d_c%0d_state", idx, c), state, v.seq[c]);
      chk($sformatf("v%0d_c%0d_outs", idx, c), outs, exp_outs(v.seq[c], 1'b1, v.taken, 1'b1));
      chk($sformatf("v%0d_c%0d_illegal", idx, c), illegal, 1'b0);
      step();
    end
    chk($sformatf("v%0d_cpi_end", idx), state, 4'd0);
  endtask

  // Hold mem_ready low for nwait cycles in wst; count cycles spent there.
  task automatic run_wait(input string name, input logic [6:0] o, input logic [3:0] wst,
                          input int nwait, input int exp_cnt, input logic [3:0] exp_next);
    int waited, cnt, mwcnt;
    logic left;
    logic [3:0] nxt;
    op = o; funct3 = 3'b000; Zero = 0; ALUR31 = 0; mem_ready = 1;
    waited = 0; cnt = 0; mwcnt = 0; left = 0; nxt = 4'hx;
    for (int c = 0; c < 14 && !left; c++) begin
      mem_ready = (state == wst && waited < nwait) ? 1'b0 : 1'b1;
      #1;
      chk($sformatf("%s_c%0d_outs", name, c), outs, exp_outs(state, mr_eff(mem_ready), 1'b0, 1'b1));
      if (MemWrite) mwcnt++;
      if (state == wst) begin
        cnt++;
        if (!mem_ready) waited++;
      end else if (cnt > 0) begin
        left = 1; nxt = state;
      end
      if (!left) step();
    end
    chk({name, "_cycles"}, cnt, exp_cnt);
    chk({name, "_next"}, nxt, exp_next);
    if (wst == 4'd5) chk({name, "_memwrite_cycles"}, mwcnt, exp_cnt);
    mem_ready = 1;
    step();
    to_fetch();
  endtask

  initial begin
    vecs[0]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd8, 4'd0}, 2'b00};
    vecs[1]  = '{7'b0010011, 3'b000, 1'b0, 1'b0, 1'b0, 4, {4'd0, 4'd1, 4'd7, 4'd8, 4'd0}, 2'b00};
    vecs[2]  = '{7'b0000011, 3'b000, 1'b0, 1'b0, 1'b0, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4}, 2'b00};
    vecs[3]  = '{7'b0100011, 3'b000, 1'b0, 1'b0, 1'b0, 4, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0}, 2'b01};
    vecs[4]  = '{7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 4, {4'd0, 4'd1, 4'd10, 4'd8, 4'd0}, 2'b11};
    vecs[5]  = '{7'b1100011, 3'b000, 1'b1, 1'b0, 1'b1, 3, {4'd0, 4'd1, 4'd9, 4'd0, 4'd0}, 2'b10};
    vecs[6]  = '{7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 3, {4'd0, 4'd1, 4'd9, 4'd0, 4'd0}, 2'b10};
    vecs[7]  = '{7'b1100011, 3'b001, 1'b0, 1'b0, 1'b1, 3, {4'd0, 4'd1, 4'd9, 4'd0, 4'd0}, 2'b10};
    vecs[8]  = '{7'b1100011, 3'b001, 1'b1, 1'b1, 1'b0, 3, {4'd0, 4'd1, 4'd9, 4'd0, 4'd0}, 2'b10};
    vecs[9]  = '{7'b1100011, 3'b100, 1'b0, 1'b1, 1'b1, 3, {4'd0, 4'd1, 4'd9, 4'd0, 4'd0}, 2'b10};
    vecs[10] = '{7'b1100011, 3'b101, 1'b0, 1'b1, 1'b0, 3, {4'd0, 4'd1, 4'd9, 4'd0, 4'd0}, 2'b10};
    vecs[11] = '{7'b1100011, 3'b110, 1'b1, 1'b0, 1'b0, 3, {4'd0, 4'd1, 4'd9, 4'd0, 4'd0}, 2'b10};
    vecs[12] = '{7'b1100011, 3'b111, 1'b1, 1'b0, 1'b1, 3, {4'd0, 4'd1, 4'd9, 4'd0, 4'd0}, 2'b10};
    vecs[13] = '{7'b1100011, 3'b010, 1'b1, 1'b1, 1'b0, 3, {4'd0, 4'd1, 4'd9, 4'd0, 4'd0}, 2'b10};
    vecs[14] = '{7'b1100011, 3'b011, 1'b0, 1'b0, 1'b0, 3, {4'd0, 4'd1, 4'd9, 4'd0, 4'd0}, 2'b10};

    rst_n = 0; op = 7'b0110011; funct3 = 0; Zero = 0; ALUR31 = 0; mem_ready = 1;
    #1;
    chk("reset_fetch_strobes", outs, exp_outs(4'd0, 1'b1, 1'b0, 1'b0));
    step();
    step();
    chk("reset_state", state, 4'd0);
    chk("reset_illegal", illegal, 1'b0);
    rst_n = 1;

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    run_wait("lw_wait", 7'b0000011, 4'd3, 3, WAIT_EN ? 4 : 1, 4'd4);
    run_wait("sw_wait", 7'b0100011, 4'd5, 2, WAIT_EN ? 3 : 1, 4'd0);

    // Reset while in MEMWRITE: MemWrite drops in the same cycle.
    op = 7'b0100011; mem_ready = 1;
    for (int i = 0; i < 8 && state != 4'd5; i++) step();
    chk("rst_mw_reach_state5", state, 4'd5);
    mem_ready = 0;
    #1;
    chk("rst_mw_before", MemWrite, 1'b1);
    rst_n = 0;
    #1;
    chk("rst_mw_same_cycle", MemWrite, 1'b0);
    step();
    chk("rst_mw_state_after", state, 4'd0);
    mem_ready = 1;
    #1;
    chk("rst_fetch_gated", outs, exp_outs(4'd0, 1'b1, 1'b0, 1'b0));
    rst_n = 1;
    #1;
    chk("fetch_strobes_released", {PCWrite, IRWrite}, 2'b11);

    // Reset while in ALUWB masks RegWrite.
    op = 7'b0010011;
    for (int i = 0; i < 8 && state != 4'd8; i++) step();
    chk("rst_rw_reach_state8", state, 4'd8);
    rst_n = 0;
    #1;
    chk("rst_rw_same_cycle", RegWrite, 1'b0);
    step();
    chk("rst_rw_state_after", state, 4'd0);
    rst_n = 1;

    // Unsupported opcode traps and sticks until reset.
    op = 7'b1111111;
    step();
    step();
    for (int c = 0; c < 10; c++) begin
      mem_ready = c[0];
      #1;
      chk($sformatf("trap_c%0d_state", c), state, 4'd15);
      chk($sformatf("trap_c%0d_illegal", c), illegal, 1'b1);
      chk($sformatf("trap_c%0d_outs", c), outs, 13'd0);
      step();
    end
    op = 7'b0110011;
    rst_n = 0;
    step();
    rst_n = 1;
    #1;
    chk("trap_reset_state", state, 4'd0);
    chk("trap_reset_illegal", illegal, 1'b0);

    run_vec(0, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
